uart_tx_feeder: RTL and testbench

//  Byte buffer and handshake driver upstream of the UART transmitter, in the TX clock domain.

---
 rtl/uart_tx_feeder_pkg.sv | 15 +
 rtl/uart_tx_feeder_if.sv | 29 ++
 rtl/uart_tx_feeder_fifo_sync_mem.sv | 73 +++++++
 rtl/uart_tx_feeder.sv | 87 ++++++++
 tb/tb_uart_tx_feeder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared types for the UART TX feeder: FSM state encoding and launch decision.
package uart_tx_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_START = 2'b01,
        WAIT_DONE  = 2'b10
    } fsm_state_e;

    // A byte may leave the FIFO only from IDLE, with data present and the transmitter quiet.
    function automatic logic launch_ok(fsm_state_e state, logic fifo_empty, logic tx_busy);
        return (state == IDLE) && !fifo_empty && !tx_busy;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between system logic / UART transmitter and the TX feeder.
interface uart_tx_feeder_if #(
    parameter int dataWidth = 8,
    parameter int DEPTH     = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [dataWidth-1:0] wr_data;
    logic                 wr_en;
    logic                 busy;
    logic [dataWidth-1:0] tx_p_data;
    logic                 tx_valid;
    logic                 full;
    logic                 empty;
    logic [AW:0]          count;
    logic                 overflow;

    // Feeder side
    modport slave (
        input  wr_data, wr_en, busy,
        output tx_p_data, tx_valid, full, empty, count, overflow
    );

    // System logic / transmitter side
    modport master (
        output wr_data, wr_en, busy,
        input  tx_p_data, tx_valid, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_feeder_fifo_sync_mem.sv
// Synchronous FIFO: register array, wrapping pointers and an occupancy count.
// Head (dout) is combinational from the read pointer.
module fifo_sync_mem #(
    parameter int dataWidth = 8,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [dataWidth-1:0]       din,
    output logic [dataWidth-1:0]       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [dataWidth-1:0] mem_q [DEPTH];
    logic [dataWidth-1:0] mem_d [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    // Full is judged on the registered count, so a same-cycle pop never makes room for a write.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write at the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
    end

    // Control state: cleared by reset, which discards any held bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// UART TX feeder: buffers bytes and launches one per transmitter frame,
// waiting for busy to rise and fall before offering the next byte.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int DEPTH     = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    fsm_state_e           state_q, state_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [dataWidth-1:0] tx_p_data_q, tx_p_data_d;
    logic                 overflow_q, overflow_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [dataWidth-1:0] fifo_dout;
    logic [AW:0]          fifo_count;
    logic                 launch;

    assign fifo_push = bus.wr_en && !fifo_full;
    assign launch    = launch_ok(state_q, fifo_empty, bus.busy);

    fifo_sync_mem #(
        .dataWidth (dataWidth),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State and output registers; all return to their idle values on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_p_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_p_data_q <= tx_p_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state: launch, then wait for the frame's busy rise and busy fall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (launch)   state_d = WAIT_START;
            WAIT_START: if (bus.busy) state_d = WAIT_DONE;
            WAIT_DONE:  if (!bus.busy) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs: pop the head and register it with a single-cycle strobe; flag dropped writes.
    always_comb begin
        fifo_pop    = launch;
        tx_valid_d  = launch;
        tx_p_data_d = launch ? fifo_dout : tx_p_data_q;
        overflow_d  = bus.wr_en && fifo_full;
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_p_data = tx_p_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_uart_tx_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;

    uart_tx_feeder_if #(.dataWidth(DW), .DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(.dataWidth(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: bytes waiting, and whether a launched frame is still outstanding.
    logic [DW-1:0] mq[$];
    bit            frame_open   = 0;
    bit            busy_seen    = 0;
    bit            exp_valid    = 0;
    logic [DW-1:0] exp_data     = '0;
    bit            exp_ovf      = 0;
    logic [DW-1:0] launched[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            frame_open = 0;
            busy_seen  = 0;
            exp_valid  = 0;
            exp_data   = '0;
            exp_ovf    = 0;
        end else begin
            int sz;
            bit go;
            sz        = mq.size();
            go        = !frame_open && (sz > 0) && !bus.busy;
            exp_ovf   = bus.wr_en && (sz == DEPTH);
            exp_valid = go;
            if (go) begin
                exp_data   = mq.pop_front();
                frame_open = 1;
                busy_seen  = 0;
            end else if (frame_open) begin
                if (!busy_seen) begin
                    if (bus.busy) busy_seen = 1;
                end else if (!bus.busy) begin
                    frame_open = 0;
                end
            end
            if (bus.wr_en && (sz < DEPTH)) mq.push_back(bus.wr_data);
        end
    end

    // Compare every cycle, away from the active edge; also log launched bytes.
    always @(negedge clk) begin
        chk("count",     32'(bus.count),     32'(mq.size()));
        chk("full",      32'(bus.full),      32'(mq.size() == DEPTH));
        chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
        chk("tx_valid",  32'(bus.tx_valid),  32'(exp_valid));
        chk("tx_p_data", 32'(bus.tx_p_data), 32'(exp_data));
        chk("overflow",  32'(bus.overflow),  32'(exp_ovf));
        if (rst && bus.tx_valid) launched.push_back(bus.tx_p_data);
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Acts as the transmitter (busy after each strobe) while driving random writes.
    task automatic run_tx(int n, int wr_pct);
        int dly = -1;
        int rem = 0;
        repeat (n) begin
            if (bus.tx_valid) begin
                dly = $urandom_range(0, 2);
                rem = $urandom_range(1, 6);
            end
            if (dly > 0) begin
                dly--;
                bus.busy = 1'b0;
            end else if (dly == 0 && rem > 0) begin
                bus.busy = 1'b1;
                rem--;
                if (rem == 0) dly = -1;
            end else begin
                bus.busy = ($urandom_range(0, 99) < 5);
            end
            bus.wr_en   = ($urandom_range(0, 99) < wr_pct);
            bus.wr_data = DW'($urandom);
            step();
        end
        bus.wr_en = 1'b0;
        bus.busy  = 1'b0;
    endtask

    // Push any outstanding frame handshake back to IDLE.
    task automatic settle();
        bus.wr_en = 1'b0;
        bus.busy  = 1'b1;
        step();
        bus.busy  = 1'b0;
        step(3);
    endtask

    initial begin
        int pulses;
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        bus.busy    = 1'b0;

        // 1: reset held with wr_en=1 -> nothing written
        step(5);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        bus.wr_en = 1'b0;
        rst       = 1'b1;
        step(2);

        // 2: single byte, latency and busy-gated spacing
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        chk("lat_count1", 32'(bus.count), 32'd1);
        chk("lat_valid0", 32'(bus.tx_valid), 32'd0);
        step();
        chk("lat_valid1", 32'(bus.tx_valid), 32'd1);
        chk("lat_data",   32'(bus.tx_p_data), 32'hA5);
        bus.busy = 1'b1;
        step();
        chk("strobe_1cyc", 32'(bus.tx_valid), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h3C;
        step();
        bus.wr_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.tx_valid) pulses++;
        end
        chk("no_strobe_busy", 32'(pulses), 32'd0);
        bus.busy = 1'b0;
        step();
        chk("still_quiet", 32'(bus.tx_valid), 32'd0);
        step();
        chk("second_valid", 32'(bus.tx_valid), 32'd1);
        chk("second_data",  32'(bus.tx_p_data), 32'h3C);
        bus.busy = 1'b1;
        step(3);
        bus.busy = 1'b0;
        step(2);

        // 3: overfill while busy, then drain in order
        bus.busy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = DW'(i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_full",  32'(bus.full), 32'd1);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        step();
        chk("ovf_once",  32'(bus.overflow), 32'd0);
        launched.delete();
        run_tx(120, 0);
        chk("drain_len", 32'(launched.size()), 32'd8);
        for (int i = 0; i < 8 && i < launched.size(); i++)
            chk("drain_order", 32'(launched[i]), 32'(i + 1));
        settle();

        // 4: launch coinciding with a write keeps count; wrap preserves order
        bus.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = DW'(8'h40 + i);
            step();
        end
        chk("fill4", 32'(bus.count), 32'd4);
        bus.busy    = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h44;
        step();
        bus.wr_en = 1'b0;
        chk("simul_count", 32'(bus.count), 32'd4);
        chk("simul_valid", 32'(bus.tx_valid), 32'd1);
        chk("simul_data",  32'(bus.tx_p_data), 32'h40);
        run_tx(100, 30);
        run_tx(120, 0);
        settle();

        // 5: reset while a frame is in progress with 3 bytes queued
        bus.busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = DW'(8'h50 + i);
            step();
        end
        bus.wr_en = 1'b0;
        bus.busy  = 1'b0;
        step();
        bus.busy = 1'b1;
        step(2);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        step(2);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.tx_valid) pulses++;
        end
        chk("post_rst_quiet", 32'(pulses), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        step();
        bus.wr_en = 1'b0;
        step(3);
        chk("held_by_busy", 32'(bus.tx_valid), 32'd0);
        bus.busy = 1'b0;
        step();
        chk("post_rst_launch", 32'(bus.tx_valid), 32'd1);
        chk("post_rst_data",   32'(bus.tx_p_data), 32'h77);
        settle();

        // 6: empty FIFO, busy toggling randomly
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            bus.busy = 1'($urandom);
            step();
            if (bus.tx_valid) pulses++;
        end
        chk("empty_no_strobe", 32'(pulses), 32'd0);
        settle();

        // Randomized traffic against the model
        run_tx(600, 35);
        run_tx(150, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
